vram_wr_arb: RTL

VRAM write-port arbiter and write-window scheduler for the text-mode VGA pipeline. It shares the single 72-bit VRAM write port ({8-bit color, 64-bit glyph}) between `NUM_REQ` requesters, such as the host text writer and the timer/status renderer. Writes are admitted only inside a counted window opened by the frame-start pulse from the sync generator, so on-screen cells never tear. Registered outputs drive `wraddress/data/wren` of the VRAM macro directly.

---
 rtl/vram_pkg.sv | 19 +
 rtl/vram_wr_arb_if.sv | 36 +++
 rtl/vram_wr_arb_rr_arbiter.sv | 50 +++++
 rtl/vram_wr_arb.sv | 136 +++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared VRAM geometry and types for the text-mode VGA pipeline.
// One VRAM word is a cell: 8-bit color attribute above a 64-bit glyph bitmap.
package vram_pkg;

   localparam int VRAM_ADR_W = 12;
   localparam int VRAM_DAT_W = 72;
   localparam int VRAM_CELLS = 3520;

   typedef struct packed {
      logic [7:0]  color;
      logic [63:0] glyph;
   } vram_word_t;

   typedef enum logic {
      IDLE = 1'b0,
      OPEN = 1'b1
   } wr_win_state_e;

endpackage

// File: rtl/vram_wr_arb_if.sv
// Requester handshake, frame pulse and VRAM write-port bundle of the write arbiter.
// The arbiter takes the slave view; the requesters and sync side hold the master view.
interface vram_wr_arb_if
   import vram_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADR_W   = VRAM_ADR_W,
   parameter int DAT_W   = VRAM_DAT_W
) ();

   logic                           i_frame_start;
   logic [NUM_REQ-1:0]             i_req_valid;
   logic [NUM_REQ-1:0]             o_req_ready;
   logic [NUM_REQ-1:0][ADR_W-1:0]  i_req_adr;
   logic [NUM_REQ-1:0][DAT_W-1:0]  i_req_data;
   logic                           o_vram_wr_en;
   logic [ADR_W-1:0]               o_vram_wr_adr;
   logic [DAT_W-1:0]               o_vram_wr_data;
   logic                           o_win_active;
   logic                           o_err_range;
   logic [7:0]                     o_drop_cnt;
   logic [15:0]                    o_frame_wr_cnt;

   modport slave (
      input  i_frame_start, i_req_valid, i_req_adr, i_req_data,
      output o_req_ready, o_vram_wr_en, o_vram_wr_adr, o_vram_wr_data,
      output o_win_active, o_err_range, o_drop_cnt, o_frame_wr_cnt
   );

   modport master (
      output i_frame_start, i_req_valid, i_req_adr, i_req_data,
      input  o_req_ready, o_vram_wr_en, o_vram_wr_adr, o_vram_wr_data,
      input  o_win_active, o_err_range, o_drop_cnt, o_frame_wr_cnt
   );

endinterface

// File: rtl/vram_wr_arb_rr_arbiter.sv
// Round-robin grant: first valid requester at or after ptr, wrapping around.
// ptr moves just past the granted requester only when advance is asserted.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] valid,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   nxt_ptr;
   logic [NUM_REQ-1:0] hi_mask;
   logic [NUM_REQ-1:0] hi_req;
   logic [NUM_REQ-1:0] pick;
   logic               found;

   // Requests at or above ptr win first; otherwise wrap to the lowest index.
   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         hi_mask[i] = (PTR_W'(i) >= ptr);
      end
      hi_req  = valid & hi_mask;
      pick    = (|hi_req) ? hi_req : valid;
      grant   = '0;
      nxt_ptr = ptr;
      found   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && pick[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
            nxt_ptr  = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= nxt_ptr;
      end
   end

endmodule

// File: rtl/vram_wr_arb.sv
// VRAM write-port arbiter: admits requester writes only inside a counted window
// opened by frame_start, drops out-of-range cells and drives the VRAM port from registers.
module vram_wr_arb
   import vram_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADR_W   = VRAM_ADR_W,
   parameter int DAT_W   = VRAM_DAT_W,
   parameter int MAX_ADR = VRAM_CELLS - 1,
   parameter int WIN_CYC = 4096
) (
   input  logic             clk,
   input  logic             rst_n,
   vram_wr_arb_if.slave     bus
);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   wr_win_state_e      state;
   logic [15:0]        win_cnt;
   logic               win_active;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] ready;
   logic               xfer_p0;
   logic               commit_p0;
   logic               drop_p0;
   logic [ADR_W-1:0]   sel_adr_p0;
   logic [DAT_W-1:0]   sel_data_p0;

   logic               vld_p1;
   logic [ADR_W-1:0]   wr_adr_p1;
   logic [DAT_W-1:0]   wr_data_p1;
   logic               err_p1;
   logic [7:0]         drop_cnt;
   logic [15:0]        frame_wr_cnt;

   assign win_active = (state == OPEN);

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (bus.i_req_valid),
      .advance (xfer_p0),
      .grant   (grant)
   );

   // Stage p0: handshake and selection of the single granted requester.
   always_comb begin
      ready       = win_active ? grant : '0;
      xfer_p0     = |ready;
      sel_adr_p0  = '0;
      sel_data_p0 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ready[i]) begin
            sel_adr_p0  = bus.i_req_adr[i];
            sel_data_p0 = bus.i_req_data[i];
         end
      end
      commit_p0 = xfer_p0 && (sel_adr_p0 <= ADR_W'(MAX_ADR));
      drop_p0   = xfer_p0 && !commit_p0;
   end

   // A frame_start in OPEN restarts the count instead of letting the window close.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         win_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_frame_start) begin
                  state   <= OPEN;
                  win_cnt <= 16'(WIN_CYC);
               end
            end
            OPEN: begin
               if (bus.i_frame_start) begin
                  win_cnt <= 16'(WIN_CYC);
               end else if (win_cnt == 16'd1) begin
                  state   <= IDLE;
                  win_cnt <= '0;
               end else begin
                  win_cnt <= win_cnt - 16'd1;
               end
            end
            default: begin
               state   <= IDLE;
               win_cnt <= '0;
            end
         endcase
      end
   end

   // Stage p1: registered VRAM port, error pulse and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1       <= 1'b0;
         wr_adr_p1    <= '0;
         wr_data_p1   <= '0;
         err_p1       <= 1'b0;
         drop_cnt     <= '0;
         frame_wr_cnt <= '0;
      end else begin
         vld_p1 <= commit_p0;
         err_p1 <= drop_p0;
         if (commit_p0) begin
            wr_adr_p1  <= sel_adr_p0;
            wr_data_p1 <= sel_data_p0;
         end
         if (drop_p0) begin
            drop_cnt <= sat_inc8(drop_cnt);
         end
         if (bus.i_frame_start) begin
            frame_wr_cnt <= commit_p0 ? 16'd1 : 16'd0;
         end else if (commit_p0) begin
            frame_wr_cnt <= sat_inc16(frame_wr_cnt);
         end
      end
   end

   assign bus.o_req_ready    = ready;
   assign bus.o_vram_wr_en   = vld_p1;
   assign bus.o_vram_wr_adr  = wr_adr_p1;
   assign bus.o_vram_wr_data = wr_data_p1;
   assign bus.o_win_active   = win_active;
   assign bus.o_err_range    = err_p1;
   assign bus.o_drop_cnt     = drop_cnt;
   assign bus.o_frame_wr_cnt = frame_wr_cnt;

endmodule
